// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Owns the MIPS program counter. It fetches one instruction at
//               a time over a req/ack handshake, hands it to the datapath and
//               waits for it to retire. It then selects the next PC from the
//               sequential, branch, jump or exception vector paths. Misaligned
//               fetches, fetch timeouts and external exceptions are trapped
//               at instruction boundaries.
// Ports       : clk/reset        - clock, synchronous active-high reset
//               o_imem_req       - fetch request, address is o_pc
//               i_imem_ack       - fetch acknowledge, i_imem_rdata valid now
//               i_imem_rdata     - fetched instruction word
//               o_pc             - current PC / fetch address
//               o_instr          - latched instruction
//               o_instr_valid    - one-cycle pulse, new o_instr available
//               i_exec_done      - datapath finished current instruction
//               i_stall          - hold PC update while executing
//               i_branch_taken   - branch resolved taken, to i_branch_target
//               i_jump           - unconditional jump, to i_jump_target
//               i_exc_req        - external exception request
//               o_epc            - PC of faulting/interrupted instruction
//               o_exc_cause      - 0 none, 1 misaligned, 2 timeout, 3 external
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_exec_done,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_exc_req,
  output logic [31:0] o_epc,
  output logic [1:0]  o_exc_cause
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_ST_FETCH = 2'd0;
  localparam logic [1:0] c_ST_EXEC  = 2'd1;
  localparam logic [1:0] c_ST_TRAP  = 2'd2;

  localparam logic [1:0] c_CAUSE_NONE  = 2'd0;
  localparam logic [1:0] c_CAUSE_ALIGN = 2'd1;
  localparam logic [1:0] c_CAUSE_TMO   = 2'd2;
  localparam logic [1:0] c_CAUSE_EXT   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_instr_valid;
  logic [31:0]      r_epc;
  logic [1:0]       r_exc_cause;
  logic [1:0]       r_pend_cause;   // cause captured on the way into TRAP
  logic [CNT_W-1:0] r_cnt;

  logic w_aligned;
  logic w_timeout;
  logic w_retire;

  assign w_aligned = (r_pc[1:0] == 2'b00);
  assign w_timeout = (r_cnt == c_CNT_LAST);
  assign w_retire  = i_exec_done && !i_stall;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_FETCH: begin
        if (!w_aligned) begin
          w_next_state = c_ST_TRAP;
        end else if (i_imem_ack) begin
          w_next_state = c_ST_EXEC;   // ack on the last cycle beats timeout
        end else if (w_timeout) begin
          w_next_state = c_ST_TRAP;
        end
      end
      c_ST_EXEC: begin
        if (w_retire) begin
          w_next_state = i_exc_req ? c_ST_TRAP : c_ST_FETCH;
        end
      end
      c_ST_TRAP: w_next_state = c_ST_FETCH;
      default:   w_next_state = c_ST_FETCH;
    endcase
  end

  // Output decode: a misaligned PC never reaches the bus
  always_comb begin
    o_imem_req = (r_state == c_ST_FETCH) && w_aligned;
  end

  // PC, instruction latch, timeout counter and trap bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_VECTOR;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_epc         <= 32'h0;
      r_exc_cause   <= c_CAUSE_NONE;
      r_pend_cause  <= c_CAUSE_NONE;
      r_cnt         <= '0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        c_ST_FETCH: begin
          if (!w_aligned) begin
            r_pend_cause <= c_CAUSE_ALIGN;
          end else if (i_imem_ack) begin
            r_instr       <= i_imem_rdata;
            r_instr_valid <= 1'b1;
            r_cnt         <= '0;
          end else if (w_timeout) begin
            r_pend_cause <= c_CAUSE_TMO;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_EXEC: begin
          if (w_retire) begin
            if (i_exc_req) begin
              r_pend_cause <= c_CAUSE_EXT;   // pc kept so it lands in epc
            end else if (i_jump) begin
              r_pc <= i_jump_target;
            end else if (i_branch_taken) begin
              r_pc <= i_branch_target;
            end else begin
              r_pc <= r_pc + 32'd4;          // wraps modulo 2^32
            end
          end
        end
        c_ST_TRAP: begin
          r_epc       <= r_pc;
          r_pc        <= EXC_VECTOR;
          r_exc_cause <= r_pend_cause;
        end
        default: ;
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_epc         = r_epc;
  assign o_exc_cause   = r_exc_cause;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Self-checking bench for pc_fetch_sequencer. An instruction-
//               level reference model predicts, per fetched instruction, the
//               PC, word and trap status; a monitor compares each
//               o_instr_valid pulse against those predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam logic [31:0] c_RV   = 32'h0040_0000;
  localparam logic [31:0] c_EV   = 32'h8000_0180;
  localparam int          c_TMO  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        o_imem_req;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic        i_exec_done = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_target = 32'h0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_target = 32'h0;
  logic        i_exc_req = 1'b0;
  logic [31:0] o_epc;
  logic [1:0]  o_exc_cause;

  pc_fetch_sequencer #(
    .RESET_VECTOR (c_RV),
    .EXC_VECTOR   (c_EV),
    .TIMEOUT      (c_TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .o_imem_req      (o_imem_req),
    .i_imem_ack      (i_imem_ack),
    .i_imem_rdata    (i_imem_rdata),
    .o_pc            (o_pc),
    .o_instr         (o_instr),
    .o_instr_valid   (o_instr_valid),
    .i_exec_done     (i_exec_done),
    .i_stall         (i_stall),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_exc_req       (i_exc_req),
    .o_epc           (o_epc),
    .o_exc_cause     (o_exc_cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] epc;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb_q[$];

  // Architectural model state
  logic [31:0] m_pc    = c_RV;
  logic [31:0] m_epc   = 32'h0;
  logic [1:0]  m_cause = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_trap(input logic [1:0] cause);
    m_epc   = m_pc;
    m_cause = cause;
    m_pc    = c_EV;
  endtask

  // Monitor: every instr_valid pulse must match the oldest prediction
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (o_instr_valid) begin
      chk("valid_single_pulse", {31'b0, prev_v}, 32'h0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_instr_valid: got pc %h instr %h expected no pulse", o_pc, o_instr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_pc",    o_pc,    e.pc);
        chk("sb_instr", o_instr, e.instr);
        chk("sb_epc",   o_epc,   e.epc);
        chk("sb_cause", {30'b0, o_exc_cause}, {30'b0, e.cause});
      end
    end
    prev_v = o_instr_valid;
  end

  // One instruction: fetch with latency lat (>= TIMEOUT means never acked),
  // nstall stalled cycles, then retire with the given redirect controls.
  task automatic do_txn(input int lat, input logic [31:0] rdata, input int nstall,
                        input bit exc, input bit jmp, input logic [31:0] jt,
                        input bit br, input logic [31:0] bt);
    int n;
    exp_t e;
    if (m_pc[1:0] != 2'b00) begin
      chk("misaligned_no_req", {31'b0, o_imem_req}, 32'h0);
      model_trap(2'd1);
      return;
    end
    n = 0;
    while (!o_imem_req && n < 40) begin
      cyc();
      n++;
    end
    if (!o_imem_req) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_req: got no request expected request within 40 cycles");
      return;
    end
    chk("fetch_pc", o_pc, m_pc);
    for (int k = 0; k < c_TMO; k++) begin
      if (k > 0) chk("req_held", {31'b0, o_imem_req}, 32'h1);
      i_exc_req    = 1'($urandom % 2);   // ignored outside retirement
      i_imem_rdata = (k == lat) ? rdata : $urandom;
      i_imem_ack   = (k == lat);
      if (k == lat) begin
        e.pc = m_pc; e.instr = rdata; e.epc = m_epc; e.cause = m_cause;
        sb_q.push_back(e);
      end
      cyc();
      i_imem_ack = 1'b0;
      if (k == lat) break;
    end
    i_exc_req = 1'b0;
    if (lat >= c_TMO) begin
      chk("timeout_req_drop", {31'b0, o_imem_req}, 32'h0);
      model_trap(2'd2);
      return;
    end
    // Stalled cycles: exec_done and redirects must be ignored
    for (int s = 0; s < nstall; s++) begin
      i_stall        = 1'b1;
      i_exec_done    = 1'($urandom % 2);
      i_jump         = 1'($urandom % 2);
      i_branch_taken = 1'($urandom % 2);
      i_jump_target  = $urandom;
      i_branch_target= $urandom;
      i_exc_req      = 1'($urandom % 2);
      cyc();
      chk("stall_pc_hold", o_pc, m_pc);
    end
    i_stall = 1'b0; i_exec_done = 1'b0; i_exc_req = 1'b0;
    cyc();
    chk("exec_wait_pc_hold", o_pc, m_pc);
    i_exec_done = 1'b1; i_exc_req = exc; i_jump = jmp; i_jump_target = jt;
    i_branch_taken = br; i_branch_target = bt;
    cyc();
    i_exec_done = 1'b0; i_exc_req = 1'b0; i_jump = 1'b0; i_branch_taken = 1'b0;
    if (exc)      model_trap(2'd3);
    else if (jmp) m_pc = jt;
    else if (br)  m_pc = bt;
    else          m_pc = m_pc + 32'd4;
  endtask

  function automatic logic [31:0] rand_target();
    int r;
    r = int'($urandom % 16);
    if (r == 0) return c_RV + (($urandom % 256) << 2) + ($urandom % 3) + 1;
    if (r == 1) return 32'hFFFF_FFFC;
    return c_RV + (($urandom % 1024) << 2);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    chk("rst_pc",    o_pc, c_RV);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_valid", {31'b0, o_instr_valid}, 32'h0);
    chk("rst_epc",   o_epc, 32'h0);
    chk("rst_cause", {30'b0, o_exc_cause}, 32'h0);
    reset = 1'b0;
    chk("rst_req",   {31'b0, o_imem_req}, 32'h1);

    // Directed scenarios
    do_txn(1, 32'h2008_000A, 0, 0, 0, 32'h0, 0, 32'h0);
    do_txn(0, 32'h1111_1111, 3, 0, 1, 32'h0040_0100, 1, 32'h0040_0200);
    do_txn(2, 32'h2222_2222, 0, 0, 0, 32'h0, 1, 32'h0040_0002);
    do_txn(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);          // misaligned trap
    do_txn(c_TMO, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);      // timeout trap
    do_txn(c_TMO - 1, 32'h3333_3333, 1, 0, 1, 32'h0040_0010, 0, 32'h0);
    do_txn(0, 32'h4444_4444, 0, 1, 1, 32'h0040_0300, 0, 32'h0); // external trap
    do_txn(0, 32'h5555_5555, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    do_txn(0, 32'h6666_6666, 2, 0, 0, 32'h0, 0, 32'h0);  // wraps to 0
    do_txn(1, 32'h7777_7777, 0, 0, 0, 32'h0, 0, 32'h0);

    // Reset on an ack cycle drops the ack
    while (!o_imem_req) cyc();
    i_imem_ack = 1'b1; i_imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
    cyc();
    reset = 1'b0; i_imem_ack = 1'b0;
    chk("rstack_pc",    o_pc, c_RV);
    chk("rstack_instr", o_instr, 32'h0);
    chk("rstack_valid", {31'b0, o_instr_valid}, 32'h0);
    chk("rstack_epc",   o_epc, 32'h0);
    chk("rstack_cause", {30'b0, o_exc_cause}, 32'h0);
    m_pc = c_RV; m_epc = 32'h0; m_cause = 2'd0;

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      do_txn(int'($urandom % 20), $urandom, int'($urandom % 4),
             ($urandom % 8) == 0, ($urandom % 3) == 0, rand_target(),
             ($urandom % 2) == 1, rand_target());
    end
    do_txn(0, 32'hA5A5_A5A5, 0, 0, 0, 32'h0, 0, 32'h0);
    repeat (4) cyc();
    chk("sb_drained", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Controller that owns and sequences the program counter for the MIPS core. It issues instruction-fetch requests to instruction memory with a req/ack handshake, and hands the fetched word to the datapath. It waits for the datapath to finish the instruction, then selects the next PC: sequential, branch, jump or exception vector. It also traps misaligned fetches, fetch timeouts and external exceptions at instruction boundaries.

Parameters:
RESET_VECTOR, 32'h00400000, PC value loaded on reset
EXC_VECTOR, 32'h80000180, PC value loaded on any trap
TIMEOUT, 16, max cycles imem_req may stay unacknowledged before a bus-timeout trap (>=2)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, address = pc
imem_ack  in  1  memory acknowledge, imem_rdata valid same cycle
imem_rdata  in  32  fetched instruction word
pc  out  32  current PC, also the fetch address
instr  out  32  latched instruction for the datapath
instr_valid  out  1  one-cycle pulse, new instr available
exec_done  in  1  datapath finished current instruction
stall  in  1  hold PC update while in EXEC
branch_taken  in  1  conditional branch resolved taken
branch_target  in  32  branch destination
jump  in  1  unconditional jump
jump_target  in  32  jump destination
exc_req  in  1  external exception request
epc  out  32  PC of faulting or interrupted instruction
exc_cause  out  2  0 none, 1 misaligned fetch, 2 fetch timeout, 3 external

Behaviour:
- Reset (synchronous, any state, overrides all inputs including imem_ack):
  - pc=RESET_VECTOR, state=FETCH, instr=0, instr_valid=0, epc=0, exc_cause=0, timeout count=0.
- imem_req is decoded from the registered state: 1 iff state==FETCH and pc[1:0]==0.
- States: FETCH, EXEC, TRAP.
- FETCH:
  - pc[1:0]!=0 → TRAP with cause 1, no request issued.
  - imem_ack=1 → instr<=imem_rdata, instr_valid=1 for the next cycle only, count<=0, go EXEC. Fetch latency = ack cycle + 1.
  - No ack → count increments. When count==TIMEOUT-1 and no ack → TRAP with cause 2.
  - Ack on the final timeout cycle wins over the timeout.
- EXEC:
  - Remain while exec_done=0 or stall=1; exec_done is ignored while stall=1.
  - On exec_done=1 and stall=0, the following occurs in that same edge. Priority: exc_req → TRAP with cause 3, pc unchanged. Else jump → pc<=jump_target. Else branch_taken → pc<=branch_target. Else pc<=pc+4. Non-trap cases go to FETCH.
  - jump and branch_taken both high: jump wins.
  - exc_req is sampled only here, at the instruction boundary. Elsewhere it is ignored; the requester holds it high.
- TRAP (exactly one cycle):
  - epc<=pc (faulting PC), pc<=EXC_VECTOR, exc_cause<=latched cause, go FETCH.
  - exc_cause holds until the next trap or reset.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC → 32'h00000000 with no trap. Targets are used unmodified; a misaligned target traps at the next FETCH.
- Counter width: ceil(log2(TIMEOUT)) bits; it never exceeds TIMEOUT-1.
- instr holds its value outside ack cycles; instr_valid is never high for two consecutive cycles.
- Reset during FETCH with imem_ack=1: the ack is dropped and instr stays 0.

Test Plan:
- Reset then ack on 2nd FETCH cycle with rdata=32'h2008000A → imem_req=1 at pc=32'h00400000; instr=32'h2008000A; instr_valid pulses 1 cycle; exec_done → pc=32'h00400004.
- EXEC with jump=1, jump_target=32'h00400100, branch_taken=1, branch_target=32'h00400200, stall=1 for 3 cycles, then exec_done with stall=0 → pc stays during the stall, then becomes 32'h00400100.
- branch_target=32'h00400002 taken → next FETCH imem_req=0; after the TRAP cycle, epc=32'h00400002, exc_cause=1, pc=32'h80000180.
- imem_ack held 0 → imem_req high for exactly TIMEOUT (16) cycles, then TRAP: exc_cause=2, epc=faulting pc. Repeat with ack on cycle 16 → no trap.
- exc_req=1 with exec_done=1 at pc=32'h00400010 → epc=32'h00400010, exc_cause=3, pc=32'h80000180. exc_req=1 during FETCH → no trap.
- pc=32'hFFFFFFFC, exec_done with no redirect → pc=32'h00000000. Reset asserted on an ack cycle → pc=32'h00400000, instr=0, instr_valid=0.
